// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
//   AW_DEF / DW_DEF / SQ_DEPTH_DEF : default address width, data width, store-queue depth
//   mau_state_e                    : load-path FSM states
package mau_pkg;

    localparam int unsigned AW_DEF       = 8;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned SQ_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLdMem = 2'd1,
        StRsp   = 2'd2
    } mau_state_e;

endpackage

// File: rtl/mau_store_queue.sv
// In-order store queue: circular FIFO of {addr, data} with a parallel forwarding lookup.
//   clk_i, rst_ni           : clock, async active-low reset (empties the queue)
//   push_i, push_addr_i/_data_i : enqueue at the tail (caller guarantees not full)
//   pop_i                   : dequeue the head (caller guarantees not empty)
//   head_addr_o/_data_o     : oldest entry
//   count_o, full_o         : occupancy
//   lookup_addr_i           : address to forward against
//   hit_o, hit_data_o       : youngest valid entry with a matching address
module mau_store_queue
    import mau_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = SQ_DEPTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [AW-1:0]           push_addr_i,
    input  logic [DW-1:0]           push_data_i,
    input  logic                    pop_i,
    output logic [AW-1:0]           head_addr_o,
    output logic [DW-1:0]           head_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    input  logic [AW-1:0]           lookup_addr_i,
    output logic                    hit_o,
    output logic [DW-1:0]           hit_data_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Payload needs no reset: validity is tracked by head/count only.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(DEPTH));

    // Walk oldest to youngest so the last (youngest) match overrides earlier ones.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end between execute and a 2**AW x DW data memory.
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake (one op per cycle)
//   rsp_valid/rsp_ready/rsp_rdata    : load response, held until consumed
//   mem_dadd/mem_din/mem_rwb         : registered memory port (rwb=1 writes)
//   mem_dout                         : combinational read data for mem_dadd
//   sq_count                         : store-queue occupancy
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned SQ_DEPTH = SQ_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [AW-1:0]              req_addr,
    input  logic [DW-1:0]              req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW-1:0]              rsp_rdata,
    output logic [AW-1:0]              mem_dadd,
    output logic [DW-1:0]              mem_din,
    output logic                       mem_rwb,
    input  logic [DW-1:0]              mem_dout,
    output logic [$clog2(SQ_DEPTH):0]  sq_count
);

    mau_state_e    state_q;
    logic          sq_full;
    logic          sq_hit;
    logic [DW-1:0] sq_hit_data;
    logic [AW-1:0] sq_head_addr;
    logic [DW-1:0] sq_head_data;
    logic          accept, ld_acc, st_acc, ld_miss, drain;

    // A full queue blocks stores only; loads can still be accepted.
    assign req_ready = (state_q == StIdle) && !(req_we && sq_full);
    assign accept    = req_valid && req_ready;
    assign ld_acc    = accept && !req_we;
    assign st_acc    = accept && req_we;
    assign ld_miss   = ld_acc && !sq_hit;
    // Drain only when the core is quiet or the queue is backing it up; a load miss owns the port.
    assign drain     = (sq_count != '0) && !ld_miss && (!req_valid || sq_full);

    mau_store_queue #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (SQ_DEPTH)
    ) u_store_queue (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .push_i        (st_acc),
        .push_addr_i   (req_addr),
        .push_data_i   (req_wdata),
        .pop_i         (drain),
        .head_addr_o   (sq_head_addr),
        .head_data_o   (sq_head_data),
        .count_o       (sq_count),
        .full_o        (sq_full),
        .lookup_addr_i (req_addr),
        .hit_o         (sq_hit),
        .hit_data_o    (sq_hit_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_dadd  <= '0;
            mem_din   <= '0;
            mem_rwb   <= 1'b0;
        end else begin
            // Port: rwb is high for exactly the cycle after a drain is issued.
            if (ld_miss) begin
                mem_dadd <= req_addr;
                mem_rwb  <= 1'b0;
            end else if (drain) begin
                mem_dadd <= sq_head_addr;
                mem_din  <= sq_head_data;
                mem_rwb  <= 1'b1;
            end else begin
                mem_rwb  <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (ld_acc) begin
                        if (sq_hit) begin
                            rsp_rdata <= sq_hit_data;
                            rsp_valid <= 1'b1;
                            state_q   <= StRsp;
                        end else begin
                            state_q   <= StLdMem;
                        end
                    end
                end
                StLdMem: begin
                    rsp_rdata <= mem_dout;
                    rsp_valid <= 1'b1;
                    state_q   <= StRsp;
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic [7:0]  mem_dadd;
    logic [15:0] mem_din, mem_dout;
    logic        mem_rwb;
    logic [2:0]  sq_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    logic        preload;
    int          wr_cnt;
    logic        wr_clr;
    logic [7:0]  wr_addr [8];
    logic [15:0] wr_data [8];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_dadd  (mem_dadd),
        .mem_din   (mem_din),
        .mem_rwb   (mem_rwb),
        .mem_dout  (mem_dout),
        .sq_count  (sq_count)
    );

    // Memory model: combinational read, write at the end of an rwb cycle; logs writes.
    assign mem_dout = mem[mem_dadd];
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 16'hBEEF;
            wr_cnt     <= 0;
        end else begin
            if (mem_rwb) mem[mem_dadd] <= mem_din;
            if (wr_clr) wr_cnt <= 0;
            else if (mem_rwb) begin
                if (wr_cnt < 8) begin
                    wr_addr[wr_cnt] <= mem_dadd;
                    wr_data[wr_cnt] <= mem_din;
                end
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        preload   = 1'b1;
        wr_clr    = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) cyc();
        rst_n   = 1'b1;
        preload = 1'b0;
        cyc();

        // 1. reset state
        chk("rst_rwb", mem_rwb, 0);
        chk("rst_dadd", mem_dadd, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_sq_count", sq_count, 0);
        chk("rst_req_ready", req_ready, 1);

        // 2. load miss from memory, latency 2
        drive(1'b1, 1'b0, 8'h10, 16'h0000);
        #1 chk("ld_miss_ready", req_ready, 1);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        chk("ld_miss_dadd", mem_dadd, 8'h10);
        chk("ld_miss_rwb", mem_rwb, 0);
        chk("ld_miss_no_rsp_yet", rsp_valid, 0);
        cyc();
        chk("ld_miss_rsp_valid", rsp_valid, 1);
        chk("ld_miss_rdata", rsp_rdata, 16'hBEEF);
        cyc();
        chk("ld_miss_rsp_done", rsp_valid, 0);

        // 3. store then load hit with req_valid held
        drive(1'b1, 1'b1, 8'h20, 16'h1234);
        cyc();
        drive(1'b1, 1'b0, 8'h20, 16'h0000);
        #1 chk("fwd_count", sq_count, 1);
        chk("fwd_ready", req_ready, 1);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        chk("fwd_rsp_valid", rsp_valid, 1);
        chk("fwd_rdata", rsp_rdata, 16'h1234);
        chk("fwd_no_port_read_dadd", mem_dadd, 8'h10);
        chk("fwd_no_port_read_rwb", mem_rwb, 0);
        cyc();
        chk("fwd_drain_rwb", mem_rwb, 1);
        chk("fwd_drain_dadd", mem_dadd, 8'h20);
        chk("fwd_drain_din", mem_din, 16'h1234);
        chk("fwd_drain_count", sq_count, 0);
        cyc();
        chk("fwd_rwb_one_cycle", mem_rwb, 0);
        chk("fwd_mem_written", mem[8'h20], 16'h1234);

        // 4. youngest match wins; drains in order
        wr_clr = 1'b1;
        cyc();
        wr_clr = 1'b0;
        drive(1'b1, 1'b1, 8'h30, 16'h1111);
        cyc();
        drive(1'b1, 1'b1, 8'h30, 16'h2222);
        cyc();
        drive(1'b1, 1'b0, 8'h30, 16'h0000);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        chk("young_rsp_valid", rsp_valid, 1);
        chk("young_rdata", rsp_rdata, 16'h2222);
        chk("young_count", sq_count, 2);
        repeat (4) cyc();
        chk("young_wr_cnt", wr_cnt, 2);
        chk("young_wr0_addr", wr_addr[0], 8'h30);
        chk("young_wr0_data", wr_data[0], 16'h1111);
        chk("young_wr1_data", wr_data[1], 16'h2222);
        chk("young_mem", mem[8'h30], 16'h2222);
        chk("young_count_empty", sq_count, 0);

        // 5. fill queue with req_valid held
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'h40 + 8'(i), 16'h5000 + 16'(i));
            cyc();
        end
        chk("full_count", sq_count, 4);
        drive(1'b1, 1'b1, 8'h44, 16'h5004);
        #1 chk("full_ready", req_ready, 0);
        cyc();
        chk("full_drain_count", sq_count, 3);
        chk("full_drain_rwb", mem_rwb, 1);
        chk("full_drain_dadd", mem_dadd, 8'h40);
        chk("full_drain_din", mem_din, 16'h5000);
        chk("full_ready_again", req_ready, 1);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        chk("fifth_accepted_count", sq_count, 4);
        chk("fifth_no_drain", mem_rwb, 0);
        repeat (6) cyc();
        chk("full_all_drained", sq_count, 0);
        chk("full_mem_first", mem[8'h41], 16'h5001);
        chk("full_mem_last", mem[8'h44], 16'h5004);

        // 6. response backpressure
        drive(1'b1, 1'b1, 8'h50, 16'hAAAA);
        cyc();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h50, 16'h0000);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 16'hAAAA);
            chk("bp_req_ready", req_ready, 0);
            if (k == 1) begin
                chk("bp_drain_rwb", mem_rwb, 1);
                chk("bp_drain_dadd", mem_dadd, 8'h50);
                chk("bp_drain_count", sq_count, 0);
            end
            cyc();
        end
        chk("bp_mem", mem[8'h50], 16'hAAAA);
        rsp_ready = 1'b1;
        cyc();
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_idle_ready", req_ready, 1);

        // reset while rwb is high discards the rest of the queue
        drive(1'b1, 1'b1, 8'h60, 16'h7777);
        cyc();
        drive(1'b1, 1'b1, 8'h61, 16'h8888);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 16'h0000);
        cyc();
        chk("arst_pre_rwb", mem_rwb, 1);
        chk("arst_pre_count", sq_count, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_rwb", mem_rwb, 0);
        chk("arst_count", sq_count, 0);
        chk("arst_dadd", mem_dadd, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("arst_no_drain_rwb", mem_rwb, 0);
        chk("arst_no_drain_count", sq_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
